// File: rtl/extern_return_router_buffered.sv
// Return router: pairs an index stream with a data stream and steers each
// word to one of several buffered ready/valid outputs, dropping bad indices.
module extern_return_router_buffered #(
    parameter int INDEX_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUTPUT_PORTS = 3,
    parameter int LOG_DEPTH = 4,
    parameter int OUT_FIFO_DEPTH = 2,
    parameter int USE_PORT_INDEX_MAP = 0,
    parameter int PORT_INDEX_MAP_VALUE_WIDTH = 3,
    parameter int PORT_INDEX_MAP_DEPTH = 4,
    parameter logic [0:PORT_INDEX_MAP_DEPTH-1][PORT_INDEX_MAP_VALUE_WIDTH-1:0]
        PORT_INDEX_MAP = '0,
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     input_index_valid,
    output logic                                     input_index_ready,
    input  logic [INDEX_WIDTH-1:0]                   input_index_data,
    input  logic                                     input_data_valid,
    output logic                                     input_data_ready,
    input  logic [DATA_WIDTH-1:0]                    input_data_data,
    output logic [NUM_OUTPUT_PORTS-1:0]              output_valid,
    input  logic [NUM_OUTPUT_PORTS-1:0]              output_ready,
    output logic [NUM_OUTPUT_PORTS*DATA_WIDTH-1:0]   output_data,
    output logic [LOG_DEPTH:0]                       index_fifo_count,
    output logic [DROP_COUNT_WIDTH-1:0]              drop_count,
    output logic                                     error_sticky
);

    localparam int IDX_DEPTH = 1 << LOG_DEPTH;
    localparam int OPW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int OCW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int NP = NUM_OUTPUT_PORTS;

    // Index FIFO state
    logic [INDEX_WIDTH-1:0] idx_mem_q [IDX_DEPTH];
    logic [LOG_DEPTH-1:0]   idx_wr_q;
    logic [LOG_DEPTH-1:0]   idx_rd_q;
    logic [LOG_DEPTH:0]     idx_cnt_q;
    logic                   idx_full;
    logic                   idx_empty;
    logic                   idx_push;
    logic                   idx_pop;
    logic [INDEX_WIDTH-1:0] head;

    // Output FIFO state
    logic [DATA_WIDTH-1:0]  ofifo_q [NP][OUT_FIFO_DEPTH];
    logic [OPW-1:0]         owr_q [NP];
    logic [OPW-1:0]         ord_q [NP];
    logic [OCW-1:0]         ocnt_q [NP];
    logic [NP-1:0]          ofull;
    logic [NP-1:0]          opop;
    logic [NP-1:0]          opush;

    // Routing
    int                     tgt_port;
    logic                   tgt_ok;
    logic [NP-1:0]          sel;
    logic                   room;
    logic                   data_fire;
    logic                   drop;

    logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q;
    logic                        err_q;

    function automatic logic [OPW-1:0] next_ptr(input logic [OPW-1:0] p);
        if (p == OPW'(OUT_FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + OPW'(1);
    endfunction

    assign idx_full  = (idx_cnt_q == (LOG_DEPTH+1)'(IDX_DEPTH));
    assign idx_empty = (idx_cnt_q == '0);
    assign head      = idx_mem_q[idx_rd_q];

    assign input_index_ready = !rst && !idx_full;
    assign idx_push          = input_index_valid && input_index_ready;
    assign data_fire         = input_data_valid && input_data_ready;
    assign idx_pop           = data_fire;
    assign drop              = data_fire && !tgt_ok;

    assign index_fifo_count = idx_cnt_q;
    assign drop_count       = drop_cnt_q;
    assign error_sticky     = err_q;

    // Resolve the head index to an output port and decide if it exists
    always_comb begin
        int  head_u;
        logic in_map;
        head_u   = int'(32'(head));
        tgt_port = 0;
        in_map   = 1'b0;
        if (USE_PORT_INDEX_MAP != 0) begin
            for (int i = 0; i < PORT_INDEX_MAP_DEPTH; i++) begin
                if (head_u == i) begin
                    tgt_port = int'(32'(PORT_INDEX_MAP[i]));
                    in_map   = 1'b1;
                end
            end
        end else begin
            tgt_port = head_u;
            in_map   = 1'b1;
        end
        tgt_ok = in_map && (tgt_port < NP) && (tgt_port >= 0);
    end

    // Per-port status, output presentation and data-side ready
    always_comb begin
        output_valid = '0;
        output_data  = '0;
        ofull        = '0;
        opop         = '0;
        opush        = '0;
        sel          = '0;
        room         = 1'b0;
        for (int p = 0; p < NP; p++) begin
            output_valid[p] = !rst && (ocnt_q[p] != '0);
            output_data[p*DATA_WIDTH +: DATA_WIDTH] = ofifo_q[p][ord_q[p]];
            ofull[p] = (ocnt_q[p] == OCW'(OUT_FIFO_DEPTH));
            opop[p]  = output_valid[p] && output_ready[p];
            sel[p]   = tgt_ok && (tgt_port == p);
            if (sel[p] && (!ofull[p] || opop[p])) begin
                room = 1'b1;
            end
        end
        input_data_ready = !rst && !idx_empty && (!tgt_ok || room);
        for (int p = 0; p < NP; p++) begin
            opush[p] = data_fire && sel[p];
        end
    end

    // Index FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_wr_q  <= '0;
            idx_rd_q  <= '0;
            idx_cnt_q <= '0;
        end else begin
            if (idx_push) begin
                idx_wr_q <= idx_wr_q + LOG_DEPTH'(1);
            end
            if (idx_pop) begin
                idx_rd_q <= idx_rd_q + LOG_DEPTH'(1);
            end
            if (idx_push && !idx_pop) begin
                idx_cnt_q <= idx_cnt_q + (LOG_DEPTH+1)'(1);
            end else if (!idx_push && idx_pop) begin
                idx_cnt_q <= idx_cnt_q - (LOG_DEPTH+1)'(1);
            end
        end
    end

    // Index FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (idx_push) begin
            idx_mem_q[idx_wr_q] <= input_index_data;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                owr_q[p]  <= '0;
                ord_q[p]  <= '0;
                ocnt_q[p] <= '0;
            end else begin
                if (opush[p]) begin
                    owr_q[p] <= next_ptr(owr_q[p]);
                end
                if (opop[p]) begin
                    ord_q[p] <= next_ptr(ord_q[p]);
                end
                if (opush[p] && !opop[p]) begin
                    ocnt_q[p] <= ocnt_q[p] + OCW'(1);
                end else if (!opush[p] && opop[p]) begin
                    ocnt_q[p] <= ocnt_q[p] - OCW'(1);
                end
            end
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (opush[p]) begin
                ofifo_q[p][owr_q[p]] <= input_data_data;
            end
        end
    end

    // Saturating drop counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_COUNT_WIDTH'(1);
            end
        end
    end

endmodule
